// File: rtl/asg_pkg.sv
// rtl/asg_pkg.sv - shared types for the arbitrary-signal-generator pointer blocks
package asg_pkg;

  typedef enum logic {
    PER = 1'b0,
    BST = 1'b1
  } asg_mod_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } asg_bst_state_t;

endpackage

// File: rtl/asg_ptr_mod.sv
// rtl/asg_ptr_mod.sv - modulo fixed-point table pointer (load, advance, wrap flag)
module asg_ptr_mod #(
  parameter int CWM = 14,
  parameter int CWF = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_ld,
  input  logic               i_adv,
  input  logic [CWM+CWF-1:0] i_off,
  input  logic [CWM+CWF-1:0] i_siz,
  input  logic [CWM+CWF-1:0] i_ste,
  output logic [CWM-1:0]     o_addr,
  output logic               o_wrap
);

  localparam int PW = CWM + CWF;

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_nxt;
  logic [PW:0]   w_sub;

  // One extra bit so the subtraction sign tells whether the advance crossed the table end.
  assign w_nxt  = {1'b0, r_ptr} + {1'b0, i_ste} + {{PW{1'b0}}, 1'b1};
  assign w_sub  = w_nxt - ({1'b0, i_siz} + {{PW{1'b0}}, 1'b1});
  assign o_wrap = ~w_sub[PW];
  assign o_addr = r_ptr[CWF +: CWM];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_ld) begin
      r_ptr <= i_off;
    end else if (i_adv) begin
      r_ptr <= o_wrap ? w_sub[PW-1:0] : w_nxt[PW-1:0];
    end
  end

endmodule

// File: rtl/asg_bst.sv
// rtl/asg_bst.sv - periodic/burst table pointer generator for one ASG channel
module asg_bst
  import asg_pkg::*;
#(
  parameter int CWM = 14,
  parameter int CWF = 16,
  parameter int BCW = 16,
  parameter int DCW = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic [CWM-1:0]         o_sto_tdata,
  output logic [(CWM+7)/8-1:0]   o_sto_tkeep,
  output logic                   o_sto_tlast,
  output logic                   o_sto_tvalid,
  input  logic                   i_sto_tready,
  input  logic                   i_evn_rst,
  input  logic                   i_evn_str,
  input  logic                   i_evn_stp,
  input  logic                   i_evn_swt,
  output logic                   o_evs_rst,
  output logic                   o_evs_str,
  output logic                   o_evs_stp,
  output logic                   o_evs_swt,
  input  logic                   i_ctl_trg,
  input  logic                   i_cfg_tre,
  input  logic                   i_cfg_mod,
  input  logic [CWM+CWF-1:0]     i_cfg_siz,
  input  logic [CWM+CWF-1:0]     i_cfg_ste,
  input  logic [CWM+CWF-1:0]     i_cfg_off,
  input  logic [BCW-1:0]         i_cfg_bln,
  input  logic [DCW-1:0]         i_cfg_bdl,
  input  logic [BCW-1:0]         i_cfg_bnm,
  output logic [BCW-1:0]         o_sts_pcn,
  output logic [BCW-1:0]         o_sts_bcn
);

  asg_bst_state_t r_state, w_state_nxt;
  logic [BCW-1:0] r_pcn, w_pcn_nxt;
  logic [BCW-1:0] r_bcn, w_bcn_nxt;
  logic [DCW-1:0] r_dly, w_dly_nxt;
  logic           r_msk, w_msk_nxt;
  logic           r_str, w_str_nxt;

  logic           w_ptr_clr, w_ptr_ld, w_ptr_adv;
  logic [CWM-1:0] w_addr;
  logic           w_wrap;
  logic           w_ctl_run, w_beat, w_bst, w_last_per, w_eos;
  logic [BCW-1:0] w_pcn_inc, w_bcn_inc, w_bcn_inc_sat;

  asg_ptr_mod #(.CWM(CWM), .CWF(CWF)) u_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_ptr_clr),
    .i_ld    (w_ptr_ld),
    .i_adv   (w_ptr_adv),
    .i_off   (i_cfg_off),
    .i_siz   (i_cfg_siz),
    .i_ste   (i_cfg_ste),
    .o_addr  (w_addr),
    .o_wrap  (w_wrap)
  );

  // A start event in the same cycle already qualifies the trigger.
  assign w_ctl_run     = (i_evn_swt | (i_ctl_trg & r_msk)) & (r_str | i_evn_str);
  assign w_beat        = (r_state == RUN) & i_sto_tready;
  assign w_bst         = (asg_mod_t'(i_cfg_mod) == BST);
  assign w_pcn_inc     = (&r_pcn) ? r_pcn : r_pcn + 1'b1;
  assign w_bcn_inc     = r_bcn + 1'b1;
  assign w_bcn_inc_sat = (&r_bcn) ? r_bcn : w_bcn_inc;
  assign w_last_per    = w_bst & w_wrap & (r_pcn == i_cfg_bln);
  assign w_eos         = w_last_per & (i_cfg_bnm != '0) & (w_bcn_inc == i_cfg_bnm);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pcn   <= '0;
      r_bcn   <= '0;
      r_dly   <= '0;
      r_msk   <= 1'b1;
      r_str   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcn   <= w_pcn_nxt;
      r_bcn   <= w_bcn_nxt;
      r_dly   <= w_dly_nxt;
      r_msk   <= w_msk_nxt;
      r_str   <= w_str_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcn_nxt   = r_pcn;
    w_bcn_nxt   = r_bcn;
    w_dly_nxt   = r_dly;
    w_msk_nxt   = r_msk;
    w_str_nxt   = r_str;
    w_ptr_clr   = 1'b0;
    w_ptr_ld    = 1'b0;
    w_ptr_adv   = 1'b0;
    if (i_evn_rst) begin
      w_state_nxt = IDLE;
      w_pcn_nxt   = '0;
      w_bcn_nxt   = '0;
      w_dly_nxt   = '0;
      w_msk_nxt   = 1'b1;
      w_str_nxt   = 1'b0;
      w_ptr_clr   = 1'b1;
    end else if (i_evn_stp) begin
      w_state_nxt = IDLE;
      w_msk_nxt   = 1'b1;
      w_str_nxt   = 1'b0;
    end else begin
      if (i_evn_str) begin
        w_str_nxt = 1'b1;
      end
      if (w_ctl_run) begin
        w_state_nxt = RUN;
        w_pcn_nxt   = '0;
        w_bcn_nxt   = '0;
        w_msk_nxt   = i_cfg_tre;
        w_ptr_ld    = 1'b1;
      end else begin
        case (r_state)
          RUN: begin
            if (w_beat) begin
              w_ptr_adv = 1'b1;
              if (w_last_per) begin
                w_pcn_nxt = '0;
                w_bcn_nxt = w_bcn_inc_sat;
                if (w_eos) begin
                  w_state_nxt = IDLE;
                  w_msk_nxt   = 1'b1;
                end else begin
                  w_state_nxt = PAUSE;
                  w_dly_nxt   = '0;
                end
              end else if (w_wrap) begin
                w_pcn_nxt = w_pcn_inc;
              end
            end
          end
          PAUSE: begin
            // Pause length is counted in clocks and ignores backpressure.
            if (r_dly == i_cfg_bdl) begin
              w_state_nxt = RUN;
              w_ptr_ld    = 1'b1;
            end else begin
              w_dly_nxt = r_dly + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_sto_tvalid = (r_state == RUN);
  assign o_sto_tdata  = o_sto_tvalid ? w_addr : '0;
  assign o_sto_tkeep  = '1;
  assign o_sto_tlast  = ~i_evn_rst & (i_evn_stp | (w_beat & w_eos));
  assign o_evs_rst    = 1'b0;
  assign o_evs_str    = r_str;
  assign o_evs_stp    = ~r_str;
  assign o_evs_swt    = (r_state != IDLE);
  assign o_sts_pcn    = r_pcn;
  assign o_sts_bcn    = r_bcn;

endmodule

// File: tb/tb_asg_bst.sv
// tb/tb_asg_bst.sv - randomized self-checking bench for asg_bst against a behavioural model
module tb_asg_bst;

  localparam int CWM = 14;
  localparam int CWF = 16;
  localparam int BCW = 16;
  localparam int DCW = 32;
  localparam int PW  = CWM + CWF;
  localparam int KW  = (CWM + 7) / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [CWM-1:0] tdata;
  logic [KW-1:0]  tkeep;
  logic           tlast, tvalid, tready;
  logic           evn_rst, evn_str, evn_stp, evn_swt;
  logic           evs_rst, evs_str, evs_stp, evs_swt;
  logic           trg, cfg_tre, cfg_mod;
  logic [PW-1:0]  cfg_siz, cfg_ste, cfg_off;
  logic [BCW-1:0] cfg_bln, cfg_bnm, sts_pcn, sts_bcn;
  logic [DCW-1:0] cfg_bdl;

  asg_bst #(.CWM(CWM), .CWF(CWF), .BCW(BCW), .DCW(DCW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_sto_tdata(tdata), .o_sto_tkeep(tkeep), .o_sto_tlast(tlast),
    .o_sto_tvalid(tvalid), .i_sto_tready(tready),
    .i_evn_rst(evn_rst), .i_evn_str(evn_str), .i_evn_stp(evn_stp), .i_evn_swt(evn_swt),
    .o_evs_rst(evs_rst), .o_evs_str(evs_str), .o_evs_stp(evs_stp), .o_evs_swt(evs_swt),
    .i_ctl_trg(trg), .i_cfg_tre(cfg_tre), .i_cfg_mod(cfg_mod),
    .i_cfg_siz(cfg_siz), .i_cfg_ste(cfg_ste), .i_cfg_off(cfg_off),
    .i_cfg_bln(cfg_bln), .i_cfg_bdl(cfg_bdl), .i_cfg_bnm(cfg_bnm),
    .o_sts_pcn(sts_pcn), .o_sts_bcn(sts_bcn)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: pointer kept as a plain fixed-point integer, table walk done with modulo.
  longint m_ptr, m_pause;
  bit     m_run, m_msk, m_str;
  int     m_pcn, m_bcn;
  int     cnt_beats, last_idx;
  longint beat_q[$];

  function automatic longint tbl_size();
    return longint'(cfg_siz) + 1;
  endfunction

  function automatic longint tbl_step();
    return longint'(cfg_ste) + 1;
  endfunction

  function automatic bit m_wraps();
    return (m_ptr + tbl_step()) >= tbl_size();
  endfunction

  function automatic bit m_eos();
    return cfg_mod && m_wraps() && (m_pcn == int'(cfg_bln)) && (cfg_bnm != 0) &&
           (m_bcn + 1 == int'(cfg_bnm));
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_pause = 0; m_run = 0; m_msk = 1; m_str = 0; m_pcn = 0; m_bcn = 0;
  endtask

  task automatic model_update();
    bit beat, go, w, e;
    beat = m_run & tready;
    go   = (evn_swt | (trg & m_msk)) & (m_str | evn_str);
    w    = m_wraps();
    e    = m_eos();
    if (evn_rst) begin
      model_reset();
    end else if (evn_stp) begin
      m_run = 0; m_pause = 0; m_msk = 1; m_str = 0;
    end else begin
      if (evn_str) m_str = 1;
      if (go) begin
        m_ptr = cfg_off; m_pcn = 0; m_bcn = 0; m_run = 1; m_pause = 0; m_msk = cfg_tre;
      end else if (beat) begin
        m_ptr = (m_ptr + tbl_step()) % tbl_size();
        if (w) begin
          if (!cfg_mod) begin
            if (m_pcn < 65535) m_pcn++;
          end else if (m_pcn == int'(cfg_bln)) begin
            m_pcn = 0;
            if (m_bcn < 65535) m_bcn++;
            m_run = 0;
            if (e) m_msk = 1;
            else   m_pause = longint'(cfg_bdl) + 1;
          end else begin
            m_pcn++;
          end
        end
      end else if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin
          m_run = 1; m_ptr = cfg_off;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    bit beat;
    beat = m_run & tready;
    chk("tvalid", tvalid, m_run);
    chk("tdata", tdata, m_run ? (m_ptr >> CWF) : 0);
    chk("tlast", tlast, !evn_rst && (evn_stp || (beat && m_eos())));
    chk("evs_swt", evs_swt, m_run || (m_pause > 0));
    chk("evs_str", evs_str, m_str);
    chk("evs_stp", evs_stp, !m_str);
    chk("evs_rst", evs_rst, 0);
    chk("sts_pcn", sts_pcn, m_pcn);
    chk("sts_bcn", sts_bcn, m_bcn);
    if (tvalid && tready) begin
      cnt_beats++;
      beat_q.push_back(tdata);
      if (tlast) last_idx = cnt_beats;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #1;
    evn_rst = 0; evn_str = 0; evn_stp = 0; evn_swt = 0; trg = 0;
  endtask

  task automatic run_cycles(input int n, input int ready_pct);
    for (int i = 0; i < n; i++) begin
      tready = ($urandom_range(0, 99) < ready_pct);
      cyc();
    end
    tready = 1;
  endtask

  task automatic clear_obs();
    cnt_beats = 0; last_idx = 0; beat_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tkeep", tkeep, (1 << KW) - 1);
    chk("rst_str", evs_str, 0);
    chk("rst_stp", evs_stp, 1);
    chk("rst_swt", evs_swt, 0);
    chk("rst_pcn", sts_pcn, 0);
    chk("rst_bcn", sts_bcn, 0);
  endtask

  task automatic set_cfg(input bit md, input longint siz, input longint ste, input longint off,
                         input int bln, input int bdl, input int bnm, input bit tre);
    cfg_mod = md; cfg_siz = PW'(siz); cfg_ste = PW'(ste); cfg_off = PW'(off);
    cfg_bln = BCW'(bln); cfg_bdl = DCW'(bdl); cfg_bnm = BCW'(bnm); cfg_tre = tre;
  endtask

  initial begin
    longint exp_frac[9];
    longint s;
    exp_frac = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst_n = 0; tready = 1;
    evn_rst = 0; evn_str = 0; evn_stp = 0; evn_swt = 0; trg = 0;
    set_cfg(0, 'h7FFFF, 'hFFFF, 0, 0, 0, 0, 0);
    model_reset();
    clear_obs();
    #3;
    check_reset_outputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Continuous mode, integer step 1.0 over an 8-entry table.
    evn_str = 1; cyc();
    trg = 1; cyc();
    run_cycles(40, 100);
    chk("per_pcn_after_40", sts_pcn, 5);
    evn_stp = 1; trg = 1; #1;
    chk("stp_tlast", tlast, 1);
    cyc();
    chk("stp_idle", evs_swt, 0);

    // Finite burst sequence, full throughput.
    set_cfg(1, 'h3FFFF, 'hFFFF, 0, 1, 3, 2, 0);
    clear_obs();
    evn_str = 1; trg = 1; cyc();
    run_cycles(30, 100);
    chk("bst_beats", cnt_beats, 16);
    chk("bst_tlast_idx", last_idx, 16);
    chk("bst_bcn", sts_bcn, 2);
    chk("bst_idle", evs_swt, 0);
    for (int i = 0; i < 16; i++) chk("bst_seq", beat_q[i], i % 4);

    // Same sequence under random backpressure.
    clear_obs();
    trg = 1; cyc();
    run_cycles(90, 50);
    chk("bp_beats", cnt_beats, 16);
    chk("bp_tlast_idx", last_idx, 16);
    chk("bp_bcn", sts_bcn, 2);
    for (int i = 0; i < 16 && i < beat_q.size(); i++) chk("bp_seq", beat_q[i], i % 4);

    // Fractional step of one half.
    set_cfg(0, 'h3FFFF, 'h7FFF, 0, 0, 0, 0, 0);
    trg = 1; cyc();
    clear_obs();
    run_cycles(9, 100);
    for (int i = 0; i < 9; i++) chk("frac_seq", beat_q[i], exp_frac[i]);
    evn_stp = 1; cyc();

    // Retrigger masked with cfg_tre=0.
    set_cfg(1, 'h3FFFF, 'hFFFF, 0, 1, 5, 0, 0);
    evn_str = 1; trg = 1; cyc();
    run_cycles(3, 100);
    trg = 1; cyc();
    chk("tre0_pcn", sts_pcn, 1);
    evn_stp = 1; cyc();

    // Retrigger inside PAUSE with cfg_tre=1.
    set_cfg(1, 'h3FFFF, 'hFFFF, 'h10000, 1, 5, 0, 1);
    evn_str = 1; trg = 1; cyc();
    for (int i = 0; i < 50 && !(evs_swt && !tvalid); i++) cyc();
    chk("pause_reached", evs_swt && !tvalid, 1);
    chk("pause_bcn", sts_bcn, 1);
    trg = 1; cyc();
    chk("rtg_tvalid", tvalid, 1);
    chk("rtg_tdata", tdata, 1);
    chk("rtg_pcn", sts_pcn, 0);
    chk("rtg_bcn", sts_bcn, 0);

    // Asynchronous reset in the middle of a run.
    run_cycles(20, 100);
    #2 rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Random events, triggers, backpressure and configurations.
    for (int n = 0; n < 1500; n++) begin
      if (!m_run && m_pause == 0 && $urandom_range(0, 9) == 0) begin
        s = $urandom_range('h8000, 'h7FFFF);
        set_cfg($urandom_range(0, 1), s, $urandom_range(0, int'(s)), $urandom_range(0, int'(s)),
                $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 1));
      end
      tready  = ($urandom_range(0, 99) < 70);
      trg     = ($urandom_range(0, 99) < 10);
      evn_swt = ($urandom_range(0, 99) < 3);
      evn_str = ($urandom_range(0, 99) < 5);
      evn_stp = ($urandom_range(0, 99) < 2);
      evn_rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
